// File: rtl/imem_pkg.sv
// Shared definitions for the instruction-memory fetch unit.
//   state_t           : controller state (LOAD while a program is being streamed in,
//                       RUN while the fetch port is serving requests)
//   NOP_INSTR_DEFAULT : word returned on a faulting fetch (addi x0,x0,0)
//   even_parity       : parity bit that makes {bit, word} contain an even number of ones
package imem_pkg;

    typedef enum logic {
        LOAD = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0013;

    function automatic logic even_parity(input logic [31:0] word);
        return ^word;
    endfunction

endpackage

// File: rtl/imem_byte_packer.sv
// Assembles a little-endian byte stream into 32-bit words for the program loader.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   clear       : restart assembly (byte count and partial word cleared)
//   enable      : loader is in LOAD; bytes and done are ignored otherwise
//   byte_valid  : byte_in is valid this cycle (already gated off when memory is full)
//   byte_in     : next program byte, lowest lane first
//   done        : end of program; any partial word is flushed with upper bytes zero
//   word_ready  : strobe, word must be written this cycle
//   word        : assembled word including the byte arriving this cycle
module imem_byte_packer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear,
    input  logic        enable,
    input  logic        byte_valid,
    input  logic [7:0]  byte_in,
    input  logic        done,
    output logic        word_ready,
    output logic [31:0] word
);

    logic [1:0]  cnt_q;
    logic [31:0] asm_q;
    logic        accept;
    logic [2:0]  fill;

    // A byte arriving together with done is merged before the flush, so the
    // strobe and the word are both derived from the post-merge view.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no path leaves it unassigned (which would infer a latch).
        accept     = enable & byte_valid & ~clear;
        word       = asm_q;
        if (accept) begin
            word[{cnt_q, 3'b000} +: 8] = byte_in;
        end
        fill       = {1'b0, cnt_q} + {2'b00, accept};
        word_ready = enable & ~clear & ((fill == 3'd4) | (done & (fill != 3'd0)));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values regardless of statement order.
        if (!rst_n) begin
            cnt_q <= '0;
            asm_q <= '0;
        end else if (clear | word_ready | (enable & done)) begin
            // Clearing the register keeps missing upper bytes of a later partial word at zero.
            cnt_q <= '0;
            asm_q <= '0;
        end else if (accept) begin
            cnt_q <= cnt_q + 2'd1;
            asm_q <= word;
        end
    end

endmodule

// File: rtl/imem_fetch_unit.sv
// Loadable instruction memory with a one-cycle pipelined fetch port.
// A program is streamed in byte by byte while in LOAD; load_done switches to RUN,
// where each accepted fetch_pc yields one response the following cycle.
// Misaligned PCs and PCs at or beyond the loaded program return NOP_INSTR with rsp_fault.
// Optional feature macro: IMEM_PARITY_EN (33-bit array with even parity checked on fetch).
// Ports:
//   clk, rst_n                         : clock, asynchronous active-low reset
//   load_start, load_valid, load_byte  : loader control and byte stream
//   load_done                          : end of program (flush partial word, go RUN)
//   load_busy, load_words, load_ovf    : loader status (load_ovf is sticky until load_start)
//   fetch_valid, fetch_pc, fetch_ready : fetch request handshake (byte address)
//   rsp_valid, rsp_instr               : response pulse and instruction
//   rsp_fault, rsp_perr                : response qualifiers (address fault, parity error)
module imem_fetch_unit
    import imem_pkg::*;
#(
    parameter int          DEPTH     = 64,
    parameter int          ADDR_W    = $clog2(DEPTH),
    parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_start,
    input  logic              load_valid,
    input  logic [7:0]        load_byte,
    input  logic              load_done,
    output logic              load_busy,
    output logic [ADDR_W:0]   load_words,
    output logic              load_ovf,
    input  logic              fetch_valid,
    input  logic [31:0]       fetch_pc,
    output logic              fetch_ready,
    output logic              rsp_valid,
    output logic [31:0]       rsp_instr,
    output logic              rsp_fault,
    output logic              rsp_perr
);

`ifdef IMEM_PARITY_EN
    localparam int MEM_W = 33;
`else
    localparam int MEM_W = 32;
`endif
    localparam logic [ADDR_W:0] DEPTH_CNT = (ADDR_W + 1)'(DEPTH);

    state_t            state_q, state_d;
    logic [ADDR_W:0]   words_q;
    logic              ovf_q;
    logic              in_load, full, wr_en, pk_ready;
    logic [31:0]       pk_word;
    logic              accept, pc_fault;
    logic [31:0]       pc_limit;
    logic [ADDR_W-1:0] rd_idx;
    logic [MEM_W-1:0]  mem [DEPTH];

    // ---------------- controller ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= LOAD;
        else        state_q <= state_d;
    end

    // load_start wins over load_done so a restart is never lost.
    always_comb begin
        state_d = state_q;
        if (load_start)                         state_d = LOAD;
        else if (state_q == LOAD && load_done)  state_d = RUN;
    end

    assign in_load     = (state_q == LOAD);
    assign load_busy   = in_load;
    assign fetch_ready = (state_q == RUN);
    assign load_words  = words_q;
    assign load_ovf    = ovf_q;

    // ---------------- loader ----------------
    assign full = (words_q == DEPTH_CNT);

    imem_byte_packer u_packer (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (load_start),
        .enable     (in_load),
        .byte_valid (load_valid & ~full),
        .byte_in    (load_byte),
        .done       (load_done),
        .word_ready (pk_ready),
        .word       (pk_word)
    );

    assign wr_en = pk_ready & ~full;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            words_q <= '0;
            ovf_q   <= 1'b0;
        end else if (load_start) begin
            words_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            if (wr_en)                         words_q <= words_q + 1'b1;
            if (in_load & load_valid & full)   ovf_q   <= 1'b1;
        end
    end

    // NOTE: the array has no reset; contents are only meaningful below load_words, which the range check enforces.
    always_ff @(posedge clk) begin
        if (wr_en) begin
`ifdef IMEM_PARITY_EN
            mem[words_q[ADDR_W-1:0]] <= {even_parity(pk_word), pk_word};
`else
            mem[words_q[ADDR_W-1:0]] <= pk_word;
`endif
        end
    end

    // ---------------- fetch pipeline ----------------
    // Upper PC bits are not part of the index but still make the PC out of range.
    assign accept   = fetch_valid & fetch_ready;
    assign pc_limit = 32'(words_q) << 2;
    assign pc_fault = (fetch_pc[1:0] != 2'b00) | (fetch_pc >= pc_limit);
    assign rd_idx   = fetch_pc[ADDR_W+1:2];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid <= 1'b0;
            rsp_instr <= NOP_INSTR;
            rsp_fault <= 1'b0;
        end else begin
            rsp_valid <= accept;
            rsp_fault <= accept & pc_fault;
            if (accept) begin
                rsp_instr <= pc_fault ? NOP_INSTR : mem[rd_idx][31:0];
            end
        end
    end

`ifdef IMEM_PARITY_EN
    logic perr_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) perr_q <= 1'b0;
        else        perr_q <= accept & ~pc_fault &
                              (even_parity(mem[rd_idx][31:0]) != mem[rd_idx][32]);
    end
    assign rsp_perr = perr_q;
`else
    assign rsp_perr = 1'b0;
`endif

endmodule
